mig_pattern_tester: RTL and testbench
=====================================

// Module: mig_pattern_tester
// PURPOSE
//  User-side traffic generator/checker sitting directly upstream of mig_top_module's app interface.
//  After phy_init_done, writes NUM_BURSTS bursts of a deterministic pattern via app_af/app_wdf FIFOs,
//  reads them back, compares rd_data_fifo_out against expected data and reports pass/fail + error stats.
// PARAMETERS
//  APPDATA_WIDTH  128     user data width (multiple of 32); 2 words per burst (BURST_LEN=4, 64-bit DQ)
//  NUM_BURSTS     256     bursts written then read per run (1..65535)
//  START_ADDR     31'h0   app_af_addr of first burst
//  ADDR_STEP      4       address increment per burst (= BURST_LEN)
//  SEED           32'h0   pattern base value
//  TIMEOUT_CYCLES 4096    read-data watchdog limit (used only with MIG_TESTER_TIMEOUT_EN)
// PORTS
//  clk0_tb            in   1     user clock from MIG
//  rst0_tb            in   1     async active-high reset
//  phy_init_done      in   1     MIG calibration complete
//  start              in   1     1-cycle pulse: begin a run (ignored unless IDLE or DONE)
//  app_af_afull       in   1     address FIFO almost full
//  app_wdf_afull      in   1     write-data FIFO almost full
//  app_af_wren        out  1     address/command FIFO write strobe
//  app_af_addr        out  31    command address
//  app_af_cmd         out  3     3'b000 write, 3'b001 read
//  app_wdf_wren       out  1     write-data FIFO write strobe
//  app_wdf_data       out  APPDATA_WIDTH          write data
//  app_wdf_mask_data  out  APPDATA_WIDTH/8        byte mask, always 0
//  rd_data_valid      in   1     read-data word valid
//  rd_data_fifo_out   in   APPDATA_WIDTH          read-data word
//  busy               out  1     run in progress
//  done               out  1     run complete (held until next start)
//  pass               out  1     valid with done: err_count==0 and no timeout
//  err_count          out  16    mismatching words, saturates at 16'hFFFF
//  first_err_addr     out  31    burst address of first mismatch
//  timeout            out  1     watchdog expired (0 when feature compiled out)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters cleared. Reset mid-run aborts immediately; no further strobes.
//  Pattern: word k (0/1) of burst b = {APPDATA_WIDTH/32{SEED + 2*b + k}}; addr(b) = START_ADDR + b*ADDR_STEP.
//  FSM: IDLE -start-> WAIT_INIT -phy_init_done-> WR0 <-> WR1 -> RD_CMD -> RD_WAIT -> DONE -start-> WAIT_INIT.
//  WAIT_INIT: clears err_count/first_err_addr/done/pass/timeout; busy=1.
//  WR0: when !app_af_afull && !app_wdf_afull: pulse app_af_wren (cmd 000, addr(b)) and app_wdf_wren (word0)
//   same cycle -> WR1. Otherwise hold, strobes low.
//  WR1: when !app_wdf_afull: app_wdf_wren (word1); b++; -> WR0, or RD_CMD with b=0 after last burst.
//  RD_CMD: when !app_af_afull: app_af_wren, cmd 001, addr(b); b++; after NUM_BURSTS reads -> RD_WAIT.
//  Checker runs in RD_CMD and RD_WAIT independently of command issue: each rd_data_valid word compared with
//   expected word for return counter r (burst r/2, word r%2); r++ every valid word.
//  Mismatch: err_count++ (saturating); first mismatch latches first_err_addr=addr(r/2).
//  RD_WAIT -> DONE when r reaches 2*NUM_BURSTS (last word compared that cycle). DONE: busy=0, done=1, pass set.
//  rd_data_valid outside RD_CMD/RD_WAIT ignored. Strobes registered; at most one af and one wdf write/cycle.
//  phy_init_done falling mid-run: no effect (checked only in WAIT_INIT).
// CONFIGURATION
//  MIG_TESTER_TIMEOUT_EN defined: watchdog counts cycles in RD_CMD/RD_WAIT since last rd_data_valid;
//   reaching TIMEOUT_CYCLES -> timeout=1, pass=0, -> DONE. Undefined: no watchdog, timeout tied 0.
// TESTING
//  T1 NUM_BURSTS=4, ideal memory model, no afull -> 4 wr cmds addr 0,4,8,12; 8 wdf words; done, pass=1, err_count=0.
//  T2 model corrupts burst 2 word 1 -> err_count=1, first_err_addr=31'd8, pass=0.
//  T3 app_wdf_afull held high 10 cycles while in WR1 -> no wdf strobe during stall; word1 written after release; pass=1.
//  T4 start before phy_init_done, assert it 50 cycles later -> first app_af_wren only after phy_init_done seen.
//  T5 rst0_tb pulsed mid-RD_WAIT -> outputs 0 next cycle, IDLE; fresh start completes with pass=1.
//  T6 (MIG_TESTER_TIMEOUT_EN, TIMEOUT_CYCLES=100) model drops all reads -> timeout=1, done=1, pass=0 ~100 cycles later.

Source files
------------

// File: rtl/mig_pattern_tester.sv
// Traffic generator/checker for the MIG app interface: writes NUM_BURSTS pattern bursts, reads them back, compares.
// Optional read-data watchdog is compiled in by defining MIG_TESTER_TIMEOUT_EN.
module mig_pattern_tester #(
   parameter int unsigned APPDATA_WIDTH  = 128,
   parameter int unsigned NUM_BURSTS     = 256,
   parameter logic [30:0] START_ADDR     = 31'h0,
   parameter int unsigned ADDR_STEP      = 4,
   parameter logic [31:0] SEED           = 32'h0,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                       clk0_tb,
   input  logic                       rst0_tb,
   input  logic                       phy_init_done,
   input  logic                       start,
   input  logic                       app_af_afull,
   input  logic                       app_wdf_afull,
   output logic                       app_af_wren,
   output logic [30:0]                app_af_addr,
   output logic [2:0]                 app_af_cmd,
   output logic                       app_wdf_wren,
   output logic [APPDATA_WIDTH-1:0]   app_wdf_data,
   output logic [APPDATA_WIDTH/8-1:0] app_wdf_mask_data,
   input  logic                       rd_data_valid,
   input  logic [APPDATA_WIDTH-1:0]   rd_data_fifo_out,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [15:0]                err_count,
   output logic [30:0]                first_err_addr,
   output logic                       timeout
);

   localparam int unsigned REPS        = APPDATA_WIDTH / 32;
   localparam logic [16:0] TOTAL_WORDS = 17'(2 * NUM_BURSTS);
   localparam logic [15:0] LAST_BURST  = 16'(NUM_BURSTS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_INIT, S_WR0, S_WR1, S_RD_CMD, S_RD_WAIT, S_DONE
   } state_t;

   function automatic logic [30:0] burst_addr(input logic [15:0] b);
      return START_ADDR + 31'(b) * 31'(ADDR_STEP);
   endfunction

   // Word index i (= 2*burst + word) carries SEED + i in every 32-bit lane.
   function automatic logic [APPDATA_WIDTH-1:0] pattern(input logic [31:0] idx);
      return {REPS{SEED + idx}};
   endfunction

   state_t                     state_q, state_d;
   logic [15:0]                b_q, b_d;
   logic [16:0]                r_q, r_d;
   logic [15:0]                err_count_q, err_count_d;
   logic [30:0]                first_err_addr_q, first_err_addr_d;
   logic                       pass_q, pass_d;
   logic                       done_q, done_d;
   logic                       busy_q, busy_d;
   logic                       timeout_q, timeout_d;
   logic                       af_wren_q, af_wren_d;
   logic [30:0]                af_addr_q, af_addr_d;
   logic [2:0]                 af_cmd_q, af_cmd_d;
   logic                       wdf_wren_q, wdf_wren_d;
   logic [APPDATA_WIDTH-1:0]   wdf_data_q, wdf_data_d;
   logic                       rd_active;
   logic                       wd_expired;

   assign rd_active = (state_q == S_RD_CMD) || (state_q == S_RD_WAIT);

`ifdef MIG_TESTER_TIMEOUT_EN
   logic [31:0] wd_q, wd_d;

   // Counts read-phase cycles since the last returned word; restarts with every run.
   always_comb begin
      wd_d       = wd_q;
      wd_expired = 1'b0;
      if (state_q == S_WAIT_INIT) begin
         wd_d = '0;
      end else if (rd_active) begin
         if (rd_data_valid) begin
            wd_d = '0;
         end else if (wd_q >= 32'(TIMEOUT_CYCLES - 1)) begin
            wd_expired = 1'b1;
         end else begin
            wd_d = wd_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk0_tb or posedge rst0_tb) begin
      if (rst0_tb) wd_q <= '0;
      else         wd_q <= wd_d;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
   assign wd_expired         = 1'b0;
`endif

   always_comb begin
      state_d          = state_q;
      b_d              = b_q;
      r_d              = r_q;
      err_count_d      = err_count_q;
      first_err_addr_d = first_err_addr_q;
      pass_d           = pass_q;
      timeout_d        = timeout_q;
      af_wren_d        = 1'b0;
      af_addr_d        = af_addr_q;
      af_cmd_d         = af_cmd_q;
      wdf_wren_d       = 1'b0;
      wdf_data_d       = wdf_data_q;

      // Return checker runs independently of read-command issue.
      if (rd_active && rd_data_valid) begin
         if (rd_data_fifo_out != pattern(32'(r_q))) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (err_count_q == 16'd0)    first_err_addr_d = burst_addr(r_q[16:1]);
         end
         r_d = r_q + 17'd1;
      end

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d          = S_WAIT_INIT;
               b_d              = '0;
               r_d              = '0;
               err_count_d      = '0;
               first_err_addr_d = '0;
               pass_d           = 1'b0;
               timeout_d        = 1'b0;
            end
         end
         S_WAIT_INIT: begin
            if (phy_init_done) state_d = S_WR0;
         end
         S_WR0: begin
            if (!app_af_afull && !app_wdf_afull) begin
               af_wren_d  = 1'b1;
               af_cmd_d   = 3'b000;
               af_addr_d  = burst_addr(b_q);
               wdf_wren_d = 1'b1;
               wdf_data_d = pattern(32'({b_q, 1'b0}));
               state_d    = S_WR1;
            end
         end
         S_WR1: begin
            if (!app_wdf_afull) begin
               wdf_wren_d = 1'b1;
               wdf_data_d = pattern(32'({b_q, 1'b1}));
               if (b_q == LAST_BURST) begin
                  b_d     = '0;
                  state_d = S_RD_CMD;
               end else begin
                  b_d     = b_q + 16'd1;
                  state_d = S_WR0;
               end
            end
         end
         S_RD_CMD: begin
            if (!app_af_afull) begin
               af_wren_d = 1'b1;
               af_cmd_d  = 3'b001;
               af_addr_d = burst_addr(b_q);
               if (b_q == LAST_BURST) begin
                  b_d     = '0;
                  state_d = S_RD_WAIT;
               end else begin
                  b_d = b_q + 16'd1;
               end
            end
         end
         S_RD_WAIT: begin
            if (r_d >= TOTAL_WORDS) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      if (rd_active && wd_expired) begin
         timeout_d = 1'b1;
         af_wren_d = 1'b0;
         state_d   = S_DONE;
      end

      // Verdict is latched once, on entry to DONE.
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         pass_d = (err_count_d == 16'd0) && !timeout_d;
      end
   end

   assign busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
   assign done_d = (state_d == S_DONE);

   always_ff @(posedge clk0_tb or posedge rst0_tb) begin
      if (rst0_tb) begin
         state_q          <= S_IDLE;
         b_q              <= '0;
         r_q              <= '0;
         err_count_q      <= '0;
         first_err_addr_q <= '0;
         pass_q           <= 1'b0;
         done_q           <= 1'b0;
         busy_q           <= 1'b0;
         timeout_q        <= 1'b0;
         af_wren_q        <= 1'b0;
         af_addr_q        <= '0;
         af_cmd_q         <= '0;
         wdf_wren_q       <= 1'b0;
         wdf_data_q       <= '0;
      end else begin
         state_q          <= state_d;
         b_q              <= b_d;
         r_q              <= r_d;
         err_count_q      <= err_count_d;
         first_err_addr_q <= first_err_addr_d;
         pass_q           <= pass_d;
         done_q           <= done_d;
         busy_q           <= busy_d;
         timeout_q        <= timeout_d;
         af_wren_q        <= af_wren_d;
         af_addr_q        <= af_addr_d;
         af_cmd_q         <= af_cmd_d;
         wdf_wren_q       <= wdf_wren_d;
         wdf_data_q       <= wdf_data_d;
      end
   end

   assign app_af_wren       = af_wren_q;
   assign app_af_addr       = af_addr_q;
   assign app_af_cmd        = af_cmd_q;
   assign app_wdf_wren      = wdf_wren_q;
   assign app_wdf_data      = wdf_data_q;
   assign app_wdf_mask_data = '0;
   assign busy              = busy_q;
   assign done              = done_q;
   assign pass              = pass_q;
   assign err_count         = err_count_q;
   assign first_err_addr    = first_err_addr_q;
   assign timeout           = timeout_q;

endmodule

// File: tb/tb_mig_pattern_tester.sv
// Scoreboard bench for mig_pattern_tester: memory model with random stalls/latency, expected strobes and verdicts queued per run.
`timescale 1ns/1ps
module tb_mig_pattern_tester;

   localparam int          W      = 128;
   localparam int          NB     = 4;
   localparam logic [30:0] SA     = 31'h0;
   localparam int          STEP   = 4;
   localparam logic [31:0] SEED_P = 32'hA5A5_0100;
   localparam int          TO     = 100;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           phy = 1'b0;
   logic           start = 1'b0;
   logic           af_afull = 1'b0;
   logic           wdf_afull = 1'b0;
   logic           rd_valid = 1'b0;
   logic [W-1:0]   rd_data = '0;
   logic           app_af_wren, app_wdf_wren, busy, done, pass, timeout;
   logic [30:0]    app_af_addr, first_err_addr;
   logic [2:0]     app_af_cmd;
   logic [W-1:0]   app_wdf_data;
   logic [W/8-1:0] app_wdf_mask_data;
   logic [15:0]    err_count;

   always #5 clk = ~clk;

   mig_pattern_tester #(
      .APPDATA_WIDTH(W), .NUM_BURSTS(NB), .START_ADDR(SA), .ADDR_STEP(STEP),
      .SEED(SEED_P), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk0_tb(clk), .rst0_tb(rst), .phy_init_done(phy), .start(start),
      .app_af_afull(af_afull), .app_wdf_afull(wdf_afull),
      .app_af_wren(app_af_wren), .app_af_addr(app_af_addr), .app_af_cmd(app_af_cmd),
      .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_mask_data(app_wdf_mask_data),
      .rd_data_valid(rd_valid), .rd_data_fifo_out(rd_data),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_addr(first_err_addr), .timeout(timeout)
   );

   typedef struct {
      logic [15:0] err;
      logic [30:0] first;
      logic        pss;
      logic        to;
   } res_t;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   logic [33:0]  exp_af[$];
   logic [W-1:0] exp_wdf[$];
   res_t         exp_res[$];
   bit corrupt [0:2*NB-1];
   bit rand_afull = 0, stall_mode = 0, drop_reads = 0, hold_reads = 0;
   bit phy_seen = 0, af_at = 0, wdf_at = 0;
   int rd_cmds_seen = 0, first_rd_cyc = 0, done_cyc = 0;
   int stall_w0 = -100, stall_w1 = -100;

   // Reference: burst b lives at SA + b*STEP, word k of it is SEED + 2b + k in every 32-bit lane.
   function automatic logic [30:0] ref_addr(input int b);
      return SA + 31'(b * STEP);
   endfunction

   function automatic logic [W-1:0] ref_word(input int b, input int k);
      logic [31:0]  v;
      logic [W-1:0] w;
      v = SEED_P + 32'(2 * b + k);
      for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = v;
      return w;
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Edge sampler: remembers what the DUT saw at each rising edge.
   initial forever begin
      @(posedge clk);
      cyc++;
      af_at  = af_afull;
      wdf_at = wdf_afull;
      if (phy) phy_seen = 1;
   end

   // Memory model: stores writes, returns reads in order with random gaps, optional corruption/stalls.
   logic [W-1:0] mem [int];
   logic [30:0]  mw_addr[$];
   logic [W-1:0] mw_data[$];
   logic [30:0]  rq[$];
   int rq_word = 0, stall_cnt = 0, mb = 0, mkey = 0;
   logic [30:0] ma;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         mw_addr.delete(); mw_data.delete(); rq.delete();
         rq_word = 0; stall_cnt = 0; rd_valid = 1'b0;
         af_afull = 1'b0; wdf_afull = 1'b0;
      end else begin
         rd_valid = 1'b0;
         if (rq.size() > 0 && !hold_reads && !drop_reads && $urandom_range(0, 2) != 0) begin
            mb   = int'(rq[0] - SA) / STEP;
            mkey = int'(rq[0]) * 2 + rq_word;
            rd_data = mem.exists(mkey) ? mem[mkey] : '0;
            if (mb < NB && corrupt[2*mb + rq_word]) rd_data[$urandom_range(0, W-1)] ^= 1'b1;
            rd_valid = 1'b1;
            if (rq_word == 1) begin
               rq_word = 0;
               void'(rq.pop_front());
            end else begin
               rq_word = 1;
            end
         end
         if (app_af_wren) begin
            if (app_af_cmd == 3'b000) mw_addr.push_back(app_af_addr);
            else                      rq.push_back(app_af_addr);
         end
         if (app_wdf_wren) mw_data.push_back(app_wdf_data);
         while (mw_addr.size() > 0 && mw_data.size() >= 2) begin
            ma = mw_addr.pop_front();
            mem[int'(ma) * 2]     = mw_data.pop_front();
            mem[int'(ma) * 2 + 1] = mw_data.pop_front();
         end
         if (stall_cnt > 0) begin
            wdf_afull = 1'b1;
            stall_cnt--;
         end else if (stall_mode && app_af_wren && app_af_cmd == 3'b000 && app_af_addr == ref_addr(1)) begin
            wdf_afull = 1'b1;
            stall_cnt = 9;
         end else if (rand_afull) begin
            af_afull  = ($urandom_range(0, 3) == 0);
            wdf_afull = ($urandom_range(0, 3) == 0);
         end else begin
            af_afull  = 1'b0;
            wdf_afull = 1'b0;
         end
      end
   end

   // Monitor: pops and compares whenever the DUT strobes or signals completion.
   logic [33:0]  mon_af;
   logic [W-1:0] mon_wdf;
   res_t         mon_r;
   logic         done_prev = 1'b0;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         exp_af.delete(); exp_wdf.delete(); exp_res.delete();
         done_prev = 1'b0;
      end else begin
         if (app_af_wren) begin
            $display("[TB] af  cyc=%0d cmd=%0d addr=%0h", cyc, app_af_cmd, app_af_addr);
            check("af_respects_afull", 128'(af_at || (app_af_cmd == 3'b000 && wdf_at)), 128'(0));
            if (exp_af.size() == 0) begin
               check("af_unexpected_strobe", 128'(1), 128'(0));
            end else begin
               mon_af = exp_af.pop_front();
               check("af_cmd_addr", 128'({app_af_cmd, app_af_addr}), 128'(mon_af));
            end
            if (app_af_cmd == 3'b000) check("af_after_init", 128'(phy_seen), 128'(1));
            else begin
               rd_cmds_seen++;
               if (rd_cmds_seen == 1) first_rd_cyc = cyc;
            end
         end
         if (app_wdf_wren) begin
            $display("[TB] wdf cyc=%0d data=%0h", cyc, app_wdf_data);
            check("wdf_respects_afull", 128'(wdf_at), 128'(0));
            check("wdf_mask", 128'(app_wdf_mask_data), 128'(0));
            if (stall_mode && app_wdf_data == ref_word(1, 0)) stall_w0 = cyc;
            if (stall_mode && app_wdf_data == ref_word(1, 1)) stall_w1 = cyc;
            if (exp_wdf.size() == 0) begin
               check("wdf_unexpected_strobe", 128'(1), 128'(0));
            end else begin
               mon_wdf = exp_wdf.pop_front();
               check("wdf_data", 128'(app_wdf_data), 128'(mon_wdf));
            end
         end
         if (done && !done_prev) begin
            done_cyc = cyc;
            $display("[TB] done cyc=%0d pass=%0d err=%0d first=%0h timeout=%0d",
                     cyc, pass, err_count, first_err_addr, timeout);
            if (exp_res.size() == 0) begin
               check("done_unexpected", 128'(1), 128'(0));
            end else begin
               mon_r = exp_res.pop_front();
               check("res_err_count", 128'(err_count), 128'(mon_r.err));
               check("res_first_err_addr", 128'(first_err_addr), 128'(mon_r.first));
               check("res_pass", 128'(pass), 128'(mon_r.pss));
               check("res_timeout", 128'(timeout), 128'(mon_r.to));
               check("res_busy_low", 128'(busy), 128'(0));
            end
         end
         done_prev = done;
      end
   end

   task automatic push_expectations(input bit exp_to);
      int   nerr;
      int   firsti;
      res_t r;
      for (int b = 0; b < NB; b++) exp_af.push_back({3'b000, ref_addr(b)});
      for (int b = 0; b < NB; b++)
         for (int k = 0; k < 2; k++) exp_wdf.push_back(ref_word(b, k));
      for (int b = 0; b < NB; b++) exp_af.push_back({3'b001, ref_addr(b)});
      nerr   = 0;
      firsti = -1;
      for (int i = 0; i < 2 * NB; i++) begin
         if (corrupt[i] && !exp_to) begin
            nerr++;
            if (firsti < 0) firsti = i;
         end
      end
      r.err   = 16'(nerr);
      r.first = (firsti < 0) ? 31'd0 : ref_addr(firsti / 2);
      r.pss   = (nerr == 0) && !exp_to;
      r.to    = exp_to;
      exp_res.push_back(r);
      rd_cmds_seen = 0;
   endtask

   task automatic run_case(input string name, input bit exp_to, input int init_delay, input bit extra_start);
      $display("[TB] run %s", name);
      push_expectations(exp_to);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      if (init_delay > 0) begin
         repeat (init_delay) @(negedge clk);
         check({name, "_busy_waiting_init"}, 128'({busy, done}), 128'(2'b10));
         phy = 1'b1;
      end
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (extra_start && i == 20) start = 1'b1;
         if (extra_start && i == 21) start = 1'b0;
         if (done) break;
      end
      check({name, "_done_reached"}, 128'(done), 128'(1));
      @(negedge clk);
      check({name, "_all_strobes_seen"}, 128'(exp_af.size() + exp_wdf.size() + exp_res.size()), 128'(0));
      exp_af.delete(); exp_wdf.delete(); exp_res.delete();
   endtask

   task automatic clear_corrupt();
      for (int i = 0; i < 2 * NB; i++) corrupt[i] = 0;
   endtask

   initial begin
      #1ms;
      $display("FAIL global_time_limit: got no finish expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      clear_corrupt();
      repeat (3) @(negedge clk);
      check("reset_flags", 128'({app_af_wren, app_wdf_wren, busy, done, pass, timeout}), 128'(0));
      check("reset_counts", 128'({err_count, first_err_addr, app_af_addr, app_af_cmd}), 128'(0));
      check("reset_wdf_data", 128'(app_wdf_data), 128'(0));
      rst = 1'b0;
      phy = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_not_busy", 128'({busy, done}), 128'(0));

      run_case("T1_ideal", 0, 0, 0);

      corrupt[2*2 + 1] = 1;
      run_case("T2_corrupt_b2w1", 0, 0, 0);
      clear_corrupt();

      stall_mode = 1;
      run_case("T3_wdf_stall", 0, 0, 0);
      stall_mode = 0;
      check("T3_stall_gap_ge_11", 128'(stall_w1 - stall_w0 >= 11), 128'(1));

      phy = 1'b0;
      @(negedge clk) phy_seen = 0;
      run_case("T4_late_init", 0, 50, 0);

      for (int n = 0; n < 4; n++) begin
         rand_afull = 1;
         for (int i = 0; i < 2 * NB; i++) corrupt[i] = ($urandom_range(0, 3) == 0);
         run_case("RND", 0, 0, n == 1);
         rand_afull = 0;
      end
      clear_corrupt();

      // Reset while parked in RD_WAIT with returns held back.
      $display("[TB] run T5_reset_mid_read");
      hold_reads = 1;
      push_expectations(0);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < 2000 && rd_cmds_seen < NB; i++) @(negedge clk);
      check("T5_reads_issued", 128'(rd_cmds_seen), 128'(NB));
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("T5_rst_flags", 128'({app_af_wren, app_wdf_wren, busy, done, pass, timeout}), 128'(0));
      check("T5_rst_counts", 128'({err_count, first_err_addr, app_af_addr, app_af_cmd}), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      hold_reads = 0;
      repeat (10) @(negedge clk);
      check("T5_idle_after_reset", 128'({busy, done}), 128'(0));
      run_case("T5_fresh_run", 0, 0, 0);

`ifdef MIG_TESTER_TIMEOUT_EN
      drop_reads = 1;
      run_case("T6_timeout", 1, 0, 0);
      check("T6_timeout_latency", 128'((done_cyc - first_rd_cyc >= 90) && (done_cyc - first_rd_cyc <= 110)), 128'(1));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
